// File: rtl/grant_monitor.sv
// grant_monitor: watches the per-client grant and request lines behind the
// token-ring arbiter. It tracks the resource owner, measures each ownership
// session, flags ack overlap (sticky) and flags clients that are left waiting.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_FREE  | no ack held, resource unowned
// S_OWNED | exactly one client holds the resource, session being timed
// S_ERROR | two or more acks were seen together; stays here until reset
module grant_monitor #(
  parameter int CW       = 8,
  parameter int WW       = 8,
  parameter int MAX_WAIT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          reqA,
  input  logic          reqB,
  input  logic          reqC,
  input  logic          ackA,
  input  logic          ackB,
  input  logic          ackC,
  output logic [1:0]    owner,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] last_len,
  output logic          violation,
  output logic [2:0]    starve
);

  typedef enum logic [1:0] {S_FREE, S_OWNED, S_ERROR} state_t;

  localparam logic [1:0] OWNER_NONE = 2'b11;

  state_t               state_q, state_d;
  logic [1:0]           owner_q, owner_d;
  logic                 done_q, done_d;
  logic [CW-1:0]        last_len_q, last_len_d;
  logic                 violation_q, violation_d;
  logic [2:0]           starve_q, starve_d;
  logic [CW-1:0]        sess_q, sess_d;
  logic [2:0][WW-1:0]   wait_q, wait_d;

  logic [2:0] ack;
  logic [2:0] req;
  logic [1:0] nack;
  logic [1:0] ack_idx;
  logic       owner_ack;

  assign ack  = {ackC, ackB, ackA};
  assign req  = {reqC, reqB, reqA};
  assign nack = {1'b0, ack[0]} + {1'b0, ack[1]} + {1'b0, ack[2]};

  // Decode the single active ack and the current owner's own ack line
  always_comb begin
    ack_idx   = 2'd0;
    owner_ack = 1'b0;
    case (ack)
      3'b010:  ack_idx = 2'd1;
      3'b100:  ack_idx = 2'd2;
      default: ack_idx = 2'd0;
    endcase
    case (owner_q)
      2'd0:    owner_ack = ack[0];
      2'd1:    owner_ack = ack[1];
      2'd2:    owner_ack = ack[2];
      default: owner_ack = 1'b0;
    endcase
  end

  // Ownership FSM: next state, owner, session timing and violation flag
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    done_d      = 1'b0;
    last_len_d  = last_len_q;
    violation_d = violation_q;
    sess_d      = sess_q;
    case (state_q)
      S_FREE: begin
        if (nack == 2'd1) begin
          state_d = S_OWNED;
          owner_d = ack_idx;
          sess_d  = CW'(1);
        end else if (nack >= 2'd2) begin
          state_d     = S_ERROR;
          owner_d     = OWNER_NONE;
          violation_d = 1'b1;
        end
      end
      S_OWNED: begin
        if (nack >= 2'd2) begin
          // overlap aborts the session without reporting its length
          state_d     = S_ERROR;
          owner_d     = OWNER_NONE;
          violation_d = 1'b1;
        end else if (owner_ack) begin
          sess_d = (sess_q == '1) ? sess_q : sess_q + CW'(1);
        end else if (nack == 2'd0) begin
          state_d    = S_FREE;
          owner_d    = OWNER_NONE;
          done_d     = 1'b1;
          last_len_d = sess_q;
        end else begin
          // clean handover: close this session and open the next one
          owner_d    = ack_idx;
          done_d     = 1'b1;
          last_len_d = sess_q;
          sess_d     = CW'(1);
        end
      end
      S_ERROR: begin
        owner_d     = OWNER_NONE;
        violation_d = 1'b1;
      end
      default: begin
        state_d = S_FREE;
        owner_d = OWNER_NONE;
      end
    endcase
  end

  // Per-client wait counters and sticky starvation flags, active in every state
  always_comb begin
    wait_d   = wait_q;
    starve_d = starve_q;
    for (int i = 0; i < 3; i++) begin
      if (req[i] && !ack[i]) begin
        wait_d[i] = (wait_q[i] == '1) ? wait_q[i] : wait_q[i] + WW'(1);
      end else begin
        wait_d[i] = '0;
      end
      if (wait_d[i] == WW'(MAX_WAIT)) begin
        starve_d[i] = 1'b1;
      end
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FREE;
      owner_q     <= OWNER_NONE;
      done_q      <= 1'b0;
      last_len_q  <= '0;
      violation_q <= 1'b0;
      starve_q    <= 3'b000;
      sess_q      <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      done_q      <= done_d;
      last_len_q  <= last_len_d;
      violation_q <= violation_d;
      starve_q    <= starve_d;
      sess_q      <= sess_d;
      wait_q      <= wait_d;
    end
  end

  assign owner     = owner_q;
  assign busy      = (state_q == S_OWNED);
  assign done      = done_q;
  assign last_len  = last_len_q;
  assign violation = violation_q;
  assign starve    = starve_q;

endmodule

// File: tb/tb_grant_monitor.sv
// Bench for grant_monitor: directed vector table, hand-written corner
// sequences and randomized traffic against a behavioural session model.
module tb_grant_monitor;

  localparam int MAXW = 64;

  logic clk = 1'b0;
  logic reset;
  logic reqA, reqB, reqC, ackA, ackB, ackC;

  logic [1:0] owner8, owner4;
  logic       busy8, busy4, done8, done4, viol8, viol4;
  logic [7:0] last8;
  logic [3:0] last4;
  logic [2:0] starve8, starve4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  grant_monitor #(.CW(8), .WW(8), .MAX_WAIT(MAXW)) dut8 (
    .clk(clk), .reset(reset),
    .reqA(reqA), .reqB(reqB), .reqC(reqC),
    .ackA(ackA), .ackB(ackB), .ackC(ackC),
    .owner(owner8), .busy(busy8), .done(done8), .last_len(last8),
    .violation(viol8), .starve(starve8)
  );

  grant_monitor #(.CW(4), .WW(8), .MAX_WAIT(MAXW)) dut4 (
    .clk(clk), .reset(reset),
    .reqA(reqA), .reqB(reqB), .reqC(reqC),
    .ackA(ackA), .ackB(ackB), .ackC(ackC),
    .owner(owner4), .busy(busy4), .done(done4), .last_len(last4),
    .violation(viol4), .starve(starve4)
  );

  // behavioural model: owner as -1/0/1/2, unbounded session length in cycles
  bit       m_err;
  int       m_own;
  int       m_len;
  int       m_last;
  bit       m_done;
  bit       m_viol;
  int       m_wait [3];
  bit [2:0] m_starve;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_update(input bit r, input logic [2:0] rq, input logic [2:0] ak);
    int n;
    int idx;
    if (r) begin
      m_err = 0; m_own = -1; m_len = 0; m_last = 0; m_done = 0; m_viol = 0;
      m_starve = 3'b000;
      for (int i = 0; i < 3; i++) m_wait[i] = 0;
    end else begin
      n   = int'(ak[0]) + int'(ak[1]) + int'(ak[2]);
      idx = ak[1] ? 1 : (ak[2] ? 2 : 0);
      m_done = 0;
      if (!m_err) begin
        if (n >= 2) begin
          m_err = 1; m_viol = 1; m_own = -1;
        end else if (m_own < 0) begin
          if (n == 1) begin m_own = idx; m_len = 1; end
        end else if (ak[m_own]) begin
          m_len++;
        end else begin
          m_done = 1;
          m_last = m_len;
          if (n == 1) begin m_own = idx; m_len = 1; end
          else m_own = -1;
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (rq[i] && !ak[i]) m_wait[i] = (m_wait[i] < 255) ? m_wait[i] + 1 : 255;
        else m_wait[i] = 0;
        if (m_wait[i] == MAXW) m_starve[i] = 1'b1;
      end
    end
  endtask

  task automatic model_compare();
    int e_owner;
    e_owner = (m_own < 0) ? 3 : m_own;
    chk("owner",     int'(owner8), e_owner);
    chk("busy",      int'(busy8),  (m_own >= 0) ? 1 : 0);
    chk("done",      int'(done8),  int'(m_done));
    chk("last_len",  int'(last8),  (m_last > 255) ? 255 : m_last);
    chk("violation", int'(viol8),  int'(m_viol));
    chk("starve",    int'(starve8), int'(m_starve));
    chk("last_len_cw4", int'(last4), (m_last > 15) ? 15 : m_last);
    chk("owner_cw4", int'(owner4), e_owner);
  endtask

  // drive one cycle of inputs, clock it, then compare DUTs to the model
  task automatic step(input bit r, input logic [2:0] rq, input logic [2:0] ak);
    reset = r;
    {reqC, reqB, reqA} = rq;
    {ackC, ackB, ackA} = ak;
    @(posedge clk);
    model_update(r, rq, ak);
    #1;
    model_compare();
  endtask

  typedef struct {
    bit         rst;
    logic [2:0] ack;
    int         e_owner;
    int         e_busy;
    int         e_done;
    int         e_last;
    int         e_viol;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input bit r, input logic [2:0] a, input int o, input int b,
                      input int d, input int l, input int v);
    vec_t x;
    x.rst = r; x.ack = a; x.e_owner = o; x.e_busy = b; x.e_done = d;
    x.e_last = l; x.e_viol = v;
    tbl.push_back(x);
  endtask

  initial begin
    logic [2:0] rq;
    logic [2:0] ak;
    bit         r;

    reset = 1'b1;
    {reqC, reqB, reqA} = 3'b000;
    {ackC, ackB, ackA} = 3'b000;

    // single session, handover, violation, reset recovery
    addv(1, 3'b000, 3, 0, 0, 0, 0);
    addv(1, 3'b000, 3, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) addv(0, 3'b010, 1, 1, 0, 0, 0);
    addv(0, 3'b000, 3, 0, 1, 5, 0);
    addv(0, 3'b000, 3, 0, 0, 5, 0);
    for (int i = 0; i < 3; i++) addv(0, 3'b001, 0, 1, 0, 5, 0);
    addv(0, 3'b100, 2, 1, 1, 3, 0);
    addv(0, 3'b100, 2, 1, 0, 3, 0);
    addv(0, 3'b000, 3, 0, 1, 2, 0);
    addv(0, 3'b000, 3, 0, 0, 2, 0);
    addv(0, 3'b101, 3, 0, 0, 2, 1);
    addv(0, 3'b001, 3, 0, 0, 2, 1);
    addv(0, 3'b010, 3, 0, 0, 2, 1);
    addv(0, 3'b000, 3, 0, 0, 2, 1);
    addv(1, 3'b000, 3, 0, 0, 0, 0);
    addv(0, 3'b100, 2, 1, 0, 0, 0);
    addv(0, 3'b110, 3, 0, 0, 0, 1);
    addv(1, 3'b000, 3, 0, 0, 0, 0);

    foreach (tbl[k]) begin
      step(tbl[k].rst, 3'b000, tbl[k].ack);
      chk("tbl_owner", int'(owner8), tbl[k].e_owner);
      chk("tbl_busy",  int'(busy8),  tbl[k].e_busy);
      chk("tbl_done",  int'(done8),  tbl[k].e_done);
      chk("tbl_last",  int'(last8),  tbl[k].e_last);
      chk("tbl_viol",  int'(viol8),  tbl[k].e_viol);
    end

    // starvation of client C at exactly MAX_WAIT waiting cycles
    for (int i = 0; i < MAXW - 1; i++) step(0, 3'b100, 3'b000);
    chk("starve_before", int'(starve8), 0);
    step(0, 3'b100, 3'b000);
    chk("starve_at_max", int'(starve8), 4);
    for (int i = 0; i < 3; i++) step(0, 3'b100, 3'b100);
    chk("starve_sticky", int'(starve8), 4);
    chk("starve_owner", int'(owner8), 2);
    step(0, 3'b000, 3'b000);

    // reset in the middle of a 4-cycle session owned by B
    for (int i = 0; i < 4; i++) step(0, 3'b000, 3'b010);
    step(1, 3'b000, 3'b010);
    chk("midrst_owner", int'(owner8), 3);
    chk("midrst_busy",  int'(busy8), 0);
    chk("midrst_done",  int'(done8), 0);
    chk("midrst_last",  int'(last8), 0);
    chk("midrst_viol",  int'(viol8), 0);
    chk("midrst_starve", int'(starve8), 0);

    // session counter saturation on the narrow instance
    for (int i = 0; i < 20; i++) step(0, 3'b000, 3'b001);
    step(0, 3'b000, 3'b000);
    chk("sat_last_cw4", int'(last4), 15);
    chk("sat_last_cw8", int'(last8), 20);
    chk("sat_done_cw4", int'(done4), 1);

    // randomized traffic
    rq = 3'b000;
    ak = 3'b000;
    for (int c = 0; c < 4000; c++) begin
      r = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 19) == 0) rq = 3'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 39))
          0:       ak = 3'($urandom);
          1, 2, 3, 4, 5, 6, 7, 8, 9, 10: ak = 3'b000;
          default: ak = 3'b001 << $urandom_range(0, 2);
        endcase
      end
      step(r, rq, ak);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
